// File: rtl/mem_access_fsm_pkg.sv
// Shared types and constants for the multi-cycle memory sequencer.
package mem_access_fsm_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  mask_t;

  // Canonical RV NOP (addi x0, x0, 0), shown on inst until the first fetch lands
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IF_REQ,
    IF_WAIT,
    EXE,
    RD_REQ,
    RD_WAIT,
    WB,
    WR_REQ,
    WR_WAIT
  } mem_fsm_state_enum;

  // Instruction memory returns a 64-bit line; pick the 32-bit half addressed by pc[2]
  function automatic logic [31:0] selectInstWord(input data_t line, input logic upperHalf);
    return upperHalf ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/mem_access_fsm_ift.sv
// Valid/ready memory port: independent read and write channels, each a request plus a reply.
interface Mem_ift;
  import mem_access_fsm_pkg::*;

  logic  r_request_valid;
  logic  r_request_ready;
  addr_t raddr;
  logic  r_reply_valid;
  logic  r_reply_ready;
  data_t rdata;

  logic  w_request_valid;
  logic  w_request_ready;
  addr_t waddr;
  data_t wdata;
  mask_t wmask;
  logic  w_reply_valid;
  logic  w_reply_ready;

  modport Master (
    output r_request_valid, raddr, r_reply_ready,
    output w_request_valid, waddr, wdata, wmask, w_reply_ready,
    input  r_request_ready, r_reply_valid, rdata,
    input  w_request_ready, w_reply_valid
  );

  modport Slave (
    input  r_request_valid, raddr, r_reply_ready,
    input  w_request_valid, waddr, wdata, wmask, w_reply_ready,
    output r_request_ready, r_reply_valid, rdata,
    output w_request_ready, w_reply_valid
  );

endinterface

// File: rtl/mem_access_fsm.sv
// Memory sequencer between the core datapath and its instruction/data ports.
// Fetches one instruction, does at most one load or store for it, and holds
// the core in stall until the instruction's commit cycle.
module mem_access_fsm #(
  parameter logic [31:0] NOP_INST = mem_access_fsm_pkg::NOP_INST
) (
  input  logic         clk,
  input  logic         rstn,
  Mem_ift.Master       imem_ift,
  Mem_ift.Master       dmem_ift,
  input  logic [63:0]  pc,
  input  logic         re_mem,
  input  logic         we_mem,
  input  logic [63:0]  alu_res,
  input  logic [63:0]  data_package,
  input  logic [7:0]   mask_package,
  output logic [31:0]  inst,
  output logic [63:0]  rdata,
  output logic         stall
);
  import mem_access_fsm_pkg::*;

  mem_fsm_state_enum r_state;
  mem_fsm_state_enum w_nextState;

  logic [31:0] r_inst;
  data_t       r_rdata;

  logic w_iReqValid;
  logic w_iReplyReady;
  logic w_dRdReqValid;
  logic w_dRdReplyReady;
  logic w_dWrReqValid;
  logic w_dWrReplyReady;
  logic w_commit;
  logic w_unused;

  // State register; reset parks the sequencer at the start of a fetch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IF_REQ;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: advance only when the handshake of the current channel completes
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IF_REQ:  if (imem_ift.r_request_ready) w_nextState = IF_WAIT;
      IF_WAIT: if (imem_ift.r_reply_valid)   w_nextState = EXE;
      EXE: begin
        if (re_mem) begin
          w_nextState = RD_REQ;
        end else if (we_mem) begin
          w_nextState = WR_REQ;
        end else begin
          w_nextState = IF_REQ;
        end
      end
      RD_REQ:  if (dmem_ift.r_request_ready) w_nextState = RD_WAIT;
      RD_WAIT: if (dmem_ift.r_reply_valid)   w_nextState = WB;
      WB:      w_nextState = IF_REQ;
      WR_REQ:  if (dmem_ift.w_request_ready) w_nextState = WR_WAIT;
      WR_WAIT: if (dmem_ift.w_reply_valid)   w_nextState = IF_REQ;
      default: w_nextState = IF_REQ;
    endcase
  end

  // Handshake strobes and commit decoded purely from state (plus the decode flags / write reply)
  always_comb begin
    w_iReqValid     = 1'b0;
    w_iReplyReady   = 1'b0;
    w_dRdReqValid   = 1'b0;
    w_dRdReplyReady = 1'b0;
    w_dWrReqValid   = 1'b0;
    w_dWrReplyReady = 1'b0;
    w_commit        = 1'b0;
    case (r_state)
      IF_REQ:  w_iReqValid     = 1'b1;
      IF_WAIT: w_iReplyReady   = 1'b1;
      EXE:     w_commit        = ~re_mem & ~we_mem;
      RD_REQ:  w_dRdReqValid   = 1'b1;
      RD_WAIT: w_dRdReplyReady = 1'b1;
      WB:      w_commit        = 1'b1;
      WR_REQ:  w_dWrReqValid   = 1'b1;
      WR_WAIT: begin
        w_dWrReplyReady = 1'b1;
        w_commit        = dmem_ift.w_reply_valid;
      end
      default: w_commit = 1'b0;
    endcase
  end

  // Latch the fetched instruction word and the raw load reply on their capturing edges only
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inst  <= NOP_INST;
      r_rdata <= '0;
    end else begin
      if (r_state == IF_WAIT && imem_ift.r_reply_valid) begin
        r_inst <= selectInstWord(imem_ift.rdata, pc[2]);
      end
      if (r_state == RD_WAIT && dmem_ift.r_reply_valid) begin
        r_rdata <= dmem_ift.rdata;
      end
    end
  end

  // Valids/readies are also gated by rstn so they fall the moment reset asserts,
  // even though the state is already IF_REQ at that point.
  assign imem_ift.r_request_valid = w_iReqValid & rstn;
  assign imem_ift.raddr           = {pc[63:3], 3'b000};
  assign imem_ift.r_reply_ready   = w_iReplyReady & rstn;
  assign imem_ift.w_request_valid = 1'b0;
  assign imem_ift.waddr           = '0;
  assign imem_ift.wdata           = '0;
  assign imem_ift.wmask           = '0;
  assign imem_ift.w_reply_ready   = 1'b0;

  assign dmem_ift.r_request_valid = w_dRdReqValid & rstn;
  assign dmem_ift.raddr           = alu_res;
  assign dmem_ift.r_reply_ready   = w_dRdReplyReady & rstn;
  assign dmem_ift.w_request_valid = w_dWrReqValid & rstn;
  assign dmem_ift.waddr           = alu_res;
  assign dmem_ift.wdata           = data_package;
  assign dmem_ift.wmask           = mask_package;
  assign dmem_ift.w_reply_ready   = w_dWrReplyReady & rstn;

  assign inst  = r_inst;
  assign rdata = r_rdata;
  assign stall = ~w_commit;

  // The instruction port never writes, and fetches are line-aligned
  assign w_unused = ^{pc[1:0], imem_ift.w_request_ready, imem_ift.w_reply_valid};

endmodule
